vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
- Shares one single-port synchronous video RAM (1-cycle read latency) between the display pixel fetch and N_WR writer clients, e.g. board renderer and cursor/mouse overlay.
- Display fetch has absolute priority, so the 1440x900 scan-out never stalls.
- Writers are served in round-robin bursts in the gaps the fetch leaves.
- Sits between the VGA timing/fetch path and the VRAM macro, in the pixel clock domain.

Parameters:
- N_WR, 2, number of writer clients (1..4).
- ADDR_W, 21, VRAM address width; covers 1440*900 = 1 296 000 pixels.
- DATA_W, 12, pixel width (4:4:4 RGB).
- MAX_BURST, 16, maximum consecutive writes granted to one writer before rotation (≥1).

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- vblnk  in  1  vertical blanking flag from VGA timing
- rd_req  in  1  display fetch request, sampled every cycle
- rd_addr  in  ADDR_W  fetch address
- rd_valid  out  1  fetch data valid
- rd_data  out  DATA_W  fetched pixel
- wr_req  in  N_WR  per-writer request, held until acked
- wr_addr  in  N_WR*ADDR_W  packed per-writer address, writer i at [i*ADDR_W +: ADDR_W]
- wr_data  in  N_WR*DATA_W  packed per-writer data
- wr_ack  out  N_WR  one-cycle pulse per completed write
- mem_en  out  1  VRAM enable
- mem_we  out  1  VRAM write enable
- mem_addr  out  ADDR_W  VRAM address
- mem_wdata  out  DATA_W  VRAM write data
- mem_rdata  in  DATA_W  VRAM read data, valid 1 cycle after mem_en with mem_we = 0

Behaviour:
- All mem_* outputs, wr_ack and rd_valid are registered.
- Reset values are 0 for every output. FSM resets to IDLE and the round-robin pointer to 0.

Display fetch:
- rd_req = 1 at edge k puts mem_en = 1, mem_we = 0, mem_addr = rd_addr in cycle k+1.
- rd_valid = 1 with rd_data = mem_rdata in cycle k+2.
- Latency is exactly 2, back-to-back every cycle, and a fetch is never refused.

Write window:
- win = 1 always. It is restricted only by the optional feature.
- A write slot exists in a cycle when rd_req = 0 and win = 1.

FSM IDLE:
- In a write slot, pick the first writer with wr_req set, searching from the pointer upward and wrapping modulo N_WR.
- That writer becomes owner and its write issues in the same cycle.
- Burst count is set to 1 and the FSM goes to BURST.
- No request, or no slot: stay in IDLE.

FSM BURST:
- Each write slot where wr_req[owner] = 1 issues one write:
  - mem_en = 1, mem_we = 1
  - addr/data taken from the owner's slice
  - wr_ack[owner] = 1, all in the next cycle
  - burst count increments
- Cycles with rd_req = 1 or win = 0 stall the burst without ending it.
- The burst ends, FSM goes to IDLE and pointer = (owner+1) mod N_WR, when either:
  - wr_req[owner] = 0 at a sampled edge, or
  - burst count reaches MAX_BURST after a write.
- The end-of-burst cycle issues nothing extra. Re-arbitration happens in IDLE on the next slot.

Writer handshake:
- A writer keeps addr/data stable while wr_req is high.
- After wr_ack it may present the next word, or drop wr_req.
- A writer that keeps wr_req high through the ack cycle gets a second write only if it is still owner. The arbiter samples wr_req again in the cycle after the ack.
- A request dropped before ack is withdrawn silently.

Simultaneous events:
- rd_req and a writer in the same cycle: the read wins and the write waits.
- At most one memory access per cycle; mem_we = 1 never coincides with a read.

Wrap-around:
- Pointer wraps N_WR-1 → 0.
- Burst count is ceil(log2(MAX_BURST+1)) bits and is cleared on entering BURST.

Reset mid-burst:
- rst asserted asynchronously clears all outputs at once; a pending ack is lost.
- Writers must re-request.

Optional Feature:
- Macro VRAM_VBLANK_ONLY_WR_EN.
- Defined: win = vblnk. Writes happen only during vertical blanking (tear-free). A burst in progress when vblnk falls stalls until the next vblnk and keeps its owner.
- Undefined: win = 1; vblnk is ignored and left unused.

Test Plan:
- Reset then rd_req held 10 cycles, rd_addr = 0..9, with mem_rdata = addr+0x100 → rd_valid high cycles 2..11, rd_data = 0x100..0x109, no wr_ack.
- wr_req = 2'b11, rd_req = 0, MAX_BURST = 16, both held → writer 0 gets 16 acks, then writer 1 gets 16, then writer 0 again; mem_we never has a gap longer than 1 cycle.
- Writer 0 busy in a burst, rd_req pulses every other cycle → writes only in rd_req = 0 cycles, read latency stays 2, owner unchanged.
- Writer 1 drops wr_req after 3 acks → FSM returns to IDLE, pointer = 0, writer 0 granted next slot.
- Define VRAM_VBLANK_ONLY_WR_EN, vblnk = 0, wr_req[0] = 1 for 100 cycles → no mem_we. vblnk rises → ack within 1 cycle. vblnk falls mid-burst → writes pause, resume next vblnk with the same owner.
- Assert rst during BURST with wr_ack pending → all outputs 0 immediately. After release, pointer = 0 and IDLE arbitration restarts from writer 0.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display fetch has absolute priority, writers share gaps round-robin.
// Optional VRAM_VBLANK_ONLY_WR_EN restricts writes to vertical blanking.
module vram_port_arbiter #(
   parameter int N_WR      = 2,
   parameter int ADDR_W    = 21,
   parameter int DATA_W    = 12,
   parameter int MAX_BURST = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     vblnk,
   input  logic                     rd_req,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic                     rd_valid,
   output logic [DATA_W-1:0]        rd_data,
   input  logic [N_WR-1:0]          wr_req,
   input  logic [N_WR*ADDR_W-1:0]   wr_addr,
   input  logic [N_WR*DATA_W-1:0]   wr_data,
   output logic [N_WR-1:0]          wr_ack,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata
);

   localparam int IW = (N_WR > 1) ? $clog2(N_WR) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state_q;
   logic [IW-1:0]     owner_q;
   logic [IW-1:0]     ptr_q;
   logic [CW-1:0]     cnt_q;
   logic              hold_q;
   logic              rd_valid_q;
   logic [N_WR-1:0]   wr_ack_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic              win;
   logic              slot;
   logic              pick_vld;
   logic [IW-1:0]     pick_idx;
   logic              wr_go_d;
   logic [IW-1:0]     wr_sel_d;
   logic              drop_d;
   logic [CW-1:0]     cnt_d;
   logic              last_d;

`ifdef VRAM_VBLANK_ONLY_WR_EN
   assign win = vblnk;
`else
   logic unused_vblnk;
   assign unused_vblnk = vblnk;
   assign win = 1'b1;
`endif

   assign slot = !rd_req && win;

   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
      return (int'(x) == N_WR - 1) ? '0 : x + 1'b1;
   endfunction

   // Walk downward so the writer closest to the pointer is the last to win.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int i = N_WR - 1; i >= 0; i--) begin
         int j;
         j = int'(ptr_q) + i;
         if (j >= N_WR) j = j - N_WR;
         if (wr_req[j]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(j);
         end
      end
   end

   // hold_q masks the ack cycle, where wr_req still shows the acked word.
   always_comb begin
      wr_go_d  = 1'b0;
      wr_sel_d = owner_q;
      drop_d   = 1'b0;
      if (!hold_q) begin
         unique case (state_q)
            IDLE: begin
               if (slot && pick_vld) begin
                  wr_go_d  = 1'b1;
                  wr_sel_d = pick_idx;
               end
            end
            BURST: begin
               if (!wr_req[owner_q]) drop_d = 1'b1;
               else if (slot) wr_go_d = 1'b1;
            end
         endcase
      end
      cnt_d  = (state_q == IDLE) ? CW'(1) : cnt_q + 1'b1;
      last_d = (cnt_d == CW'(MAX_BURST));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         hold_q      <= 1'b0;
         rd_valid_q  <= 1'b0;
         wr_ack_q    <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         rd_valid_q <= mem_en_q && !mem_we_q;
         wr_ack_q   <= '0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         hold_q     <= wr_go_d;
         if (rd_req) begin
            mem_en_q   <= 1'b1;
            mem_addr_q <= rd_addr;
         end else if (wr_go_d) begin
            mem_en_q           <= 1'b1;
            mem_we_q           <= 1'b1;
            mem_addr_q         <= wr_addr[wr_sel_d*ADDR_W +: ADDR_W];
            mem_wdata_q        <= wr_data[wr_sel_d*DATA_W +: DATA_W];
            wr_ack_q[wr_sel_d] <= 1'b1;
         end
         if (wr_go_d) begin
            owner_q <= wr_sel_d;
            cnt_q   <= cnt_d;
            if (last_d) begin
               state_q <= IDLE;
               ptr_q   <= nxt(wr_sel_d);
            end else begin
               state_q <= BURST;
            end
         end else if (drop_d) begin
            state_q <= IDLE;
            ptr_q   <= nxt(owner_q);
         end
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_valid_q ? mem_rdata : '0;
   assign wr_ack    = wr_ack_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: transaction-level reference model plus directed scenarios.
module tb_vram_port_arbiter;

   localparam int N  = 2;
   localparam int AW = 21;
   localparam int DW = 12;
   localparam int MB = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            vblnk = 1'b1;
   logic            rd_req = 1'b0;
   logic [AW-1:0]   rd_addr = '0;
   logic            rd_valid;
   logic [DW-1:0]   rd_data;
   logic [N-1:0]    wr_req = '0;
   logic [N*AW-1:0] wr_addr = '0;
   logic [N*DW-1:0] wr_data = '0;
   logic [N-1:0]    wr_ack;
   logic            mem_en, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata = '0;

   vram_port_arbiter #(.N_WR(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst), .vblnk(vblnk),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // VRAM stand-in: read data = address + 0x100, one cycle after the access.
   always @(posedge clk)
      if (mem_en && !mem_we) mem_rdata <= DW'(mem_addr + 'h100);

   int total = 0;
   int bad   = 0;
   int rem[N];
   int word[N];
   int ackq[$];
   int cyc, we_cnt, last_we, gaps;

   task automatic chk(string nm, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Reference model: who owns the port, how many words it has had,
   // where the round-robin search starts, and whether an ack is in flight.
   int            m_own = -1;
   int            m_nw  = 0;
   int            m_ptr = 0;
   bit            m_ackfly = 0;
   int            m_iss;
   bit            m_slot;
   bit            e_en = 0, e_we = 0, e_rv = 0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wd = '0, e_rd = '0;
   logic [N-1:0]  e_ack = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_own = -1; m_nw = 0; m_ptr = 0; m_ackfly = 0;
         e_en = 0; e_we = 0; e_rv = 0; e_ack = '0; e_rd = '0;
      end else begin
         e_rv = e_en && !e_we;
         e_rd = e_rv ? DW'(e_addr + 'h100) : '0;
`ifdef VRAM_VBLANK_ONLY_WR_EN
         m_slot = !rd_req && vblnk;
`else
         m_slot = !rd_req;
`endif
         m_iss = -1;
         if (!m_ackfly) begin
            if (m_own >= 0) begin
               if (!wr_req[m_own]) begin
                  m_ptr = (m_own + 1) % N;
                  m_own = -1;
               end else if (m_slot) begin
                  m_iss = m_own;
               end
            end else if (m_slot) begin
               for (int k = 0; k < N; k++)
                  if (m_iss < 0 && wr_req[(m_ptr + k) % N]) m_iss = (m_ptr + k) % N;
               if (m_iss >= 0) begin
                  m_own = m_iss;
                  m_nw  = 0;
               end
            end
         end
         m_ackfly = (m_iss >= 0);
         e_en = 0; e_we = 0; e_ack = '0;
         if (rd_req) begin
            e_en   = 1;
            e_addr = rd_addr;
         end else if (m_iss >= 0) begin
            e_en   = 1;
            e_we   = 1;
            e_addr = wr_addr[m_iss*AW +: AW];
            e_wd   = wr_data[m_iss*DW +: DW];
            e_ack[m_iss] = 1'b1;
            m_nw++;
            if (m_nw == MB) begin
               m_ptr = (m_own + 1) % N;
               m_own = -1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("mem_en", mem_en, e_en);
         chk("mem_we", mem_we, e_we);
         chk("wr_ack", wr_ack, e_ack);
         chk("rd_valid", rd_valid, e_rv);
         if (e_en) chk("mem_addr", mem_addr, e_addr);
         if (e_we) chk("mem_wdata", mem_wdata, e_wd);
         if (e_rv) chk("rd_data", rd_data, e_rd);
      end
   end

   task automatic drive_wr();
      for (int i = 0; i < N; i++) begin
         wr_req[i] = (rem[i] > 0);
         wr_addr[i*AW +: AW] = AW'(i * 'h1000 + word[i]);
         wr_data[i*DW +: DW] = DW'(i * 'h100 + word[i]);
      end
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
         for (int i = 0; i < N; i++)
            if (wr_ack[i]) begin
               ackq.push_back(i);
               word[i]++;
               rem[i]--;
            end
         if (mem_we) begin
            we_cnt++;
            if (last_we >= 0 && cyc - last_we > 2) gaps++;
            last_we = cyc;
         end
         drive_wr();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rd_req = 1'b0;
      for (int i = 0; i < N; i++) begin
         rem[i] = 0;
         word[i] = 0;
      end
      drive_wr();
      @(posedge clk);
      #1;
      rst = 1'b0;
      ackq.delete();
      we_cnt = 0;
      last_we = -1;
      gaps = 0;
   endtask

   function automatic int cnt_owner(int lo, int hi, int who);
      int c = 0;
      for (int i = lo; i <= hi && i < ackq.size(); i++)
         if (ackq[i] == who) c++;
      return c;
   endfunction

   initial begin
      int we0;
      for (int i = 0; i < N; i++) begin
         rem[i] = 0;
         word[i] = 0;
      end
      #2;
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_wr_ack", wr_ack, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);

      // Display fetch: 10 back-to-back reads, latency 2.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         rd_req = 1'b1;
         rd_addr = AW'(i);
         step(1);
         if (i >= 1) chk("rd_data_seq", rd_data, 'h100 + i - 1);
      end
      rd_req = 1'b0;
      step(1);
      chk("rd_data_last", rd_data, 'h109);
      step(1);
      chk("rd_valid_off", rd_valid, 0);
      chk("rd_no_ack", ackq.size(), 0);

      // Two writers held: 16 to writer 0, 16 to writer 1, then writer 0.
      do_reset();
      rem[0] = 40;
      rem[1] = 40;
      drive_wr();
      step(80);
      chk("rr_w0_first16", cnt_owner(0, 15, 0), 16);
      chk("rr_w1_next16", cnt_owner(16, 31, 1), 16);
      chk("rr_back_to_w0", ackq.size() > 32 ? ackq[32] : -1, 0);
      chk("rr_we_gaps", gaps, 0);

      // Writer 0 bursting while reads take every other cycle.
      do_reset();
      rem[0] = 100;
      drive_wr();
      for (int i = 0; i < 20; i++) begin
         rd_req = (i % 2 == 0);
         rd_addr = AW'(i + 32);
         step(1);
      end
      rd_req = 1'b0;
      chk("interleave_acks", ackq.size(), 10);
      chk("interleave_owner", cnt_owner(0, 9, 0), 10);

      // Writer 1 drops after 3 acks; writer 0 takes the next slot.
      do_reset();
      rem[1] = 3;
      drive_wr();
      step(1);
      rem[0] = 5;
      drive_wr();
      step(10);
      chk("drop_w1_acks", cnt_owner(0, 2, 1), 3);
      chk("drop_then_w0", ackq.size() > 3 ? ackq[3] : -1, 0);

`ifdef VRAM_VBLANK_ONLY_WR_EN
      do_reset();
      vblnk = 1'b0;
      rem[0] = 200;
      drive_wr();
      step(100);
      chk("vb_no_write", we_cnt, 0);
      vblnk = 1'b1;
      step(1);
      chk("vb_first_we", mem_we, 1);
      chk("vb_first_ack", wr_ack, 1);
      step(5);
      vblnk = 1'b0;
      rem[1] = 50;
      drive_wr();
      we0 = we_cnt;
      step(10);
      chk("vb_paused", we_cnt - we0, 0);
      vblnk = 1'b1;
      ackq.delete();
      step(4);
      chk("vb_resume_cnt", ackq.size(), 2);
      chk("vb_same_owner", cnt_owner(0, 1, 0), 2);
`else
      do_reset();
      vblnk = 1'b0;
      rem[0] = 3;
      drive_wr();
      step(2);
      chk("vblnk_ignored", ackq.size() > 0 ? ackq[0] : -1, 0);
      vblnk = 1'b1;
      we0 = 0;
`endif

      // Reset in the middle of writer 1's burst.
      do_reset();
      rem[1] = 50;
      drive_wr();
      step(1);
      rem[0] = 50;
      drive_wr();
      step(2);
      chk("pre_rst_ack", wr_ack, 2);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_ack", wr_ack, 0);
      chk("mid_rst_en", mem_en, 0);
      chk("mid_rst_we", mem_we, 0);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_rv", rd_valid, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ackq.delete();
      step(1);
      chk("post_rst_w0", ackq.size() > 0 ? ackq[0] : -1, 0);
      step(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
